mult_div_unit: RTL and testbench

//   Iterative multiply/divide responder for the 5-stage MIPS pipeline. The EX stage

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_div_step.sv | 21 ++
 rtl/mult_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and types for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH);

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } mdu_state_t;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    // Two guard bits so the borrow is unambiguous for any (WIDTH+1)-bit shifted remainder.
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_qbit  = ~w_diff[WIDTH+1];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MDU_FAST_MUL_EN to use a single-cycle multiplier for MULT/MULTU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_t         r_state, w_state_nxt;
    logic [CW-1:0]      r_count, w_count_nxt;
    logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
    logic [WIDTH-1:0]   r_opnd, w_opnd_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0]   r_lo, w_lo_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_is_div, w_is_div_nxt;
    logic               r_neg_res, w_neg_res_nxt;
    logic               r_neg_rem, w_neg_rem_nxt;
    logic               r_div0, w_div0_nxt;

    logic               w_sign_a, w_sign_b;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_qbit;
    logic [2*WIDTH-1:0] w_fix_prod;
    logic [WIDTH-1:0]   w_fix_quo, w_fix_rem;

    assign w_sign_a = is_signed_op(md_control) & op_a[WIDTH-1];
    assign w_sign_b = is_signed_op(md_control) & op_b[WIDTH-1];
    assign w_abs_a  = w_sign_a ? -op_a : op_a;
    assign w_abs_b  = w_sign_b ? -op_b : op_b;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

    // Multiply: r_prod = {accumulator, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Divide: r_prod = {partial remainder, dividend/quotient shift register}.
    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_prod[2*WIDTH-1:WIDTH]),
        .i_bit     (r_prod[WIDTH-1]),
        .i_divisor (r_opnd),
        .o_rem     (w_div_rem),
        .o_qbit    (w_div_qbit)
    );

    // With a zero divisor the remainder path reproduces |op_a|, so only LO needs forcing.
    assign w_fix_prod = r_neg_res ? -r_prod : r_prod;
    assign w_fix_quo  = r_div0 ? {WIDTH{1'b1}}
                      : (r_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0]);
    assign w_fix_rem  = r_neg_rem ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_prod_nxt    = r_prod;
        w_opnd_nxt    = r_opnd;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_is_div_nxt  = r_is_div;
        w_neg_res_nxt = r_neg_res;
        w_neg_rem_nxt = r_neg_rem;
        w_div0_nxt    = r_div0;
        w_done_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (md_control)
                        MD_MULT, MD_MULTU: begin
                            w_opnd_nxt    = w_abs_a;
                            w_is_div_nxt  = 1'b0;
                            w_neg_res_nxt = w_sign_a ^ w_sign_b;
                            w_neg_rem_nxt = 1'b0;
                            w_div0_nxt    = 1'b0;
                            w_count_nxt   = '0;
`ifdef MDU_FAST_MUL_EN
                            w_prod_nxt    = w_fast_prod;
                            w_state_nxt   = S_FIX;
`else
                            w_prod_nxt    = {{WIDTH{1'b0}}, w_abs_b};
                            w_state_nxt   = S_MUL;
`endif
                        end
                        MD_DIV, MD_DIVU: begin
                            w_prod_nxt    = {{WIDTH{1'b0}}, w_abs_a};
                            w_opnd_nxt    = w_abs_b;
                            w_is_div_nxt  = 1'b1;
                            w_neg_res_nxt = w_sign_a ^ w_sign_b;
                            w_neg_rem_nxt = w_sign_a;
                            w_div0_nxt    = (op_b == '0);
                            w_count_nxt   = '0;
                            w_state_nxt   = S_DIV;
                        end
                        MD_MTHI: w_hi_nxt = op_a;
                        MD_MTLO: w_lo_nxt = op_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                w_prod_nxt  = {w_mul_sum, r_prod[WIDTH-1:1]};
                w_count_nxt = r_count + CW'(1);
                if (r_count == LAST) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_FIX;
                end
            end
            S_DIV: begin
                w_prod_nxt  = {w_div_rem, r_prod[WIDTH-2:0], w_div_qbit};
                w_count_nxt = r_count + CW'(1);
                if (r_count == LAST) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                if (r_is_div) begin
                    w_hi_nxt = w_fix_rem;
                    w_lo_nxt = w_fix_quo;
                end else begin
                    w_hi_nxt = w_fix_prod[2*WIDTH-1:WIDTH];
                    w_lo_nxt = w_fix_prod[WIDTH-1:0];
                end
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_prod    <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_prod    <= w_prod_nxt;
            r_opnd    <= w_opnd_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_is_div  <= w_is_div_nxt;
            r_neg_res <= w_neg_res_nxt;
            r_neg_rem <= w_neg_rem_nxt;
            r_div0    <= w_div0_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed MIPS corner cases plus randomized ops.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   md_control;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clock = ~clock;

    mult_div_unit #(
        .WIDTH (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .md_control (md_control),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operand values.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] eh,
                                  output logic [31:0] el);
        longint      sa = longint'($signed(a));
        longint      sbv = longint'($signed(b));
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        eh = '0;
        el = '0;
        case (op)
            3'd0: begin p = sa * sbv; eh = p[63:32]; el = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    el = 32'hFFFFFFFF;
                    eh = a;
                end else if (op == 3'd2) begin
                    q = sa / sbv; r = sa % sbv;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    q = {32'b0, a} / {32'b0, b}; r = {32'b0, a} % {32'b0, b};
                    el = q[31:0]; eh = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
        if (op < 3'd2) return 1;
`endif
        return W + 1;
    endfunction

    // Monitor: pops one expectation per done pulse and checks result and busy length.
    initial begin
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pending op");
                    end else begin
                        e = sb.pop_front();
                        check("result_hi", hi, e.hi);
                        check("result_lo", lo, e.lo);
                        check("busy_cycles", busy_cnt, e.lat);
                        check("busy_at_done", {31'b0, busy}, 32'd0);
                    end
                    busy_cnt = 0;
                end
                if (busy) busy_cnt++;
            end
        end
    end

    task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        model(op, a, b, e.hi, e.lo);
        e.lat = lat_of(op);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
            #2;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        md_control = op;
        op_a = a;
        op_b = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (op < 3'd4) begin
            push_exp(op, a, b);
            wait_drain();
        end else begin
            if (op == 3'd4) m_hi = a;
            if (op == 3'd5) m_lo = a;
            check("mt_hi", hi, m_hi);
            check("mt_lo", lo, m_lo);
            check("mt_busy", {31'b0, busy}, 32'd0);
            check("mt_done", {31'b0, done}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_control = '0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFFFFFF, 32'h00000002);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'h00000002);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);
        run_op(3'd3, 32'h00000064, 32'h00000000);
        check("divu_zero_lo", lo, 32'hFFFFFFFF);
        check("divu_zero_hi", hi, 32'h00000064);
        run_op(3'd4, 32'h12345678, 32'h0);
        check("mthi_hi", hi, 32'h12345678);

        // MTLO while a DIV is in flight must be dropped.
        @(negedge clock);
        start = 1'b1; md_control = 3'd2; op_a = 32'd100; op_b = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        push_exp(3'd2, 32'd100, 32'd7);
        repeat (5) @(negedge clock);
        start = 1'b1; md_control = 3'd5; op_a = 32'hDEADBEEF; op_b = 32'h0;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_drain();
        check("mtlo_ignored_lo", lo, 32'd14);
        check("mtlo_ignored_hi", hi, 32'd2);

        // Asynchronous reset partway through a DIV.
        @(negedge clock);
        start = 1'b1; md_control = 3'd2; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        push_exp(3'd2, 32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clock);
        reset = 1'b0;
        run_op(3'd1, 32'd3, 32'd5);
        check("post_reset_lo", lo, 32'h0000000F);
        check("post_reset_hi", hi, 32'h00000000);

        for (int i = 0; i < 50; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a = rand_val();
            b = rand_val();
            run_op(op, a, b);
            check("rand_hi", hi, m_hi);
            check("rand_lo", lo, m_lo);
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
